// File: rtl/ej6_pkg.sv
// Shared constants for the ej6 logic-function block: truth tables, widths, reset value.
package ej6_pkg;

    localparam int unsigned K = 4;   // number of function inputs
    localparam int unsigned N = 15;  // highest input index / truth-table MSB
    localparam int unsigned NOUT = 9;

    localparam logic [N:0] F_TT = 16'hA58F;  // f = sum m(0,1,2,3,7,8,10,13,15)
    localparam logic [N:0] G_TT = 16'h30F0;  // g = sum m(4,5,6,7,12,13)
    localparam logic [N:0] H_TT = 16'hAA22;  // h = sum m(1,5,9,11,13,15)

    localparam logic RST_VAL = 1'b0;

endpackage : ej6_pkg

// File: rtl/ej6_func_core.sv
// Combinational core: three independent realizations (truth table, SOP, POS) of f, g, h.
module ej6_func_core
    import ej6_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic f_c,
    output logic g_c,
    output logic h_c,
    output logic fs_c,
    output logic fp_c,
    output logic gs_c,
    output logic gp_c,
    output logic hs_c,
    output logic hp_c
);

    logic [K-1:0] w_n;

    assign w_n = {A, B, C, D};

    // Canonical form: direct lookup into the truth-table constants.
    assign f_c = F_TT[w_n];
    assign g_c = G_TT[w_n];
    assign h_c = H_TT[w_n];

    // Minimal sum-of-products.
    assign fs_c = (~A & ~B) | (~B & ~D) | (B & C & D) | (A & B & D);
    assign gs_c = (~A & B) | (B & ~C);
    assign hs_c = (~C & D) | (A & D);

    // Minimal product-of-sums, from the complement covers:
    //   f' = BD' + A'BC' + AB'D,  g' = B' + AC,  h' = D' + A'C
    assign fp_c = (~B | D) & (A | ~B | C) & (~A | B | ~D);
    assign gp_c = B & (~A | ~C);
    assign hp_c = D & (A | ~C);

endmodule : ej6_func_core

// File: rtl/ej6_logic_functions.sv
// Top level: function core followed by a 9-bit output register with async reset.
module ej6_logic_functions
    import ej6_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic f,
    output logic g,
    output logic h,
    output logic fs,
    output logic fp,
    output logic gs,
    output logic gp,
    output logic hs,
    output logic hp
);

    logic            w_f, w_g, w_h;
    logic            w_fs, w_fp, w_gs, w_gp, w_hs, w_hp;
    logic [NOUT-1:0] w_next;
    logic [NOUT-1:0] r_out;

    ej6_func_core u_core (
        .A    (A),
        .B    (B),
        .C    (C),
        .D    (D),
        .f_c  (w_f),
        .g_c  (w_g),
        .h_c  (w_h),
        .fs_c (w_fs),
        .fp_c (w_fp),
        .gs_c (w_gs),
        .gp_c (w_gp),
        .hs_c (w_hs),
        .hp_c (w_hp)
    );

    assign w_next = {w_f, w_fs, w_fp, w_g, w_gs, w_gp, w_h, w_hs, w_hp};

    // Capture all nine results each cycle; reset clears them immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= {NOUT{RST_VAL}};
        end else begin
            r_out <= w_next;
        end
    end

    assign {f, fs, fp, g, gs, gp, h, hs, hp} = r_out;

endmodule : ej6_logic_functions

// File: tb/tb_ej6_logic_functions.sv
// Scoreboard bench for ej6_logic_functions: reset, full sweep, spot vectors, mid-sweep reset.
module tb_ej6_logic_functions;

    logic clk;
    logic reset;
    logic A, B, C, D;
    logic f, g, h, fs, fp, gs, gp, hs, hp;

    logic [8:0] sb_q[$];
    int         n_cmp;
    int         n_err;

    ej6_logic_functions dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D),
        .f     (f),
        .g     (g),
        .h     (h),
        .fs    (fs),
        .fp    (fp),
        .gs    (gs),
        .gp    (gp),
        .hs    (hs),
        .hp    (hp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] dut_vec();
        return {f, fs, fp, g, gs, gp, h, hs, hp};
    endfunction

    // Reference model built from the spec truth tables only.
    function automatic logic [8:0] model(input logic [3:0] n);
        logic [15:0] ft;
        logic [15:0] gt;
        logic [15:0] ht;
        ft = 16'hA58F;
        gt = 16'h30F0;
        ht = 16'hAA22;
        return {{3{ft[n]}}, {3{gt[n]}}, {3{ht[n]}}};
    endfunction

    task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] n);
        {A, B, C, D} = n;
        sb_q.push_back(model(n));
    endtask

    // Wait for the capturing edge, then pop and compare one expectation.
    task automatic capture_and_check(input string tag);
        logic [8:0] exp;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, dut_vec(), 9'bxxxxxxxxx);
        end else begin
            exp = sb_q.pop_front();
            check_val(tag, dut_vec(), exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        {A, B, C, D} = 4'd13;

        // Reset asserted between edges with n=13: outputs clear without a clock.
        #1 reset = 1'b1;
        #1;
        check_val("reset_async", dut_vec(), 9'h000);
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_held", dut_vec(), 9'h000);

        // Release and take one edge: n=13 gives all ones.
        @(negedge clk);
        reset = 1'b0;
        drive(4'd13);
        capture_and_check("post_reset_n13");
        check_val("post_reset_all_ones", dut_vec(), 9'h1FF);

        // Exhaustive sweep, inputs changing every cycle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(4'(i));
            capture_and_check($sformatf("sweep_n%0d", i));
            check_val($sformatf("cons_f_n%0d", i), {6'd0, fs, fp, f}, {6'd0, {3{f}}});
            check_val($sformatf("cons_g_n%0d", i), {6'd0, gs, gp, g}, {6'd0, {3{g}}});
            check_val($sformatf("cons_h_n%0d", i), {6'd0, hs, hp, h}, {6'd0, {3{h}}});
        end

        // Reverse sweep back-to-back for a different transition pattern.
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            drive(4'(i));
            capture_and_check($sformatf("rsweep_n%0d", i));
        end

        // Spot vectors against hand-written expectations {f,g,h}.
        begin
            logic [3:0] spot_n[4];
            logic [2:0] spot_fgh[4];
            spot_n   = '{4'd0, 4'd6, 4'd9, 4'd15};
            spot_fgh = '{3'b100, 3'b010, 3'b001, 3'b101};
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                drive(spot_n[k]);
                capture_and_check($sformatf("spot_sb_n%0d", spot_n[k]));
                check_val($sformatf("spot_fgh_n%0d", spot_n[k]), {6'd0, f, g, h}, {6'd0, spot_fgh[k]});
            end
        end

        // Mid-sweep reset during n=7: outputs drop before the next edge.
        @(negedge clk);
        {A, B, C, D} = 4'd6;
        @(posedge clk);
        @(negedge clk);
        {A, B, C, D} = 4'd7;
        #2 reset = 1'b1;
        #1;
        check_val("midsweep_reset_async", dut_vec(), 9'h000);
        @(posedge clk);
        #1;
        check_val("midsweep_reset_held", dut_vec(), 9'h000);
        @(negedge clk);
        reset = 1'b0;
        drive(4'd7);
        capture_and_check("midsweep_resume_n7");
        check_val("midsweep_fgh_n7", {6'd0, f, g, h}, {6'd0, 3'b110});

        check_val("sb_drained", 9'(sb_q.size()), 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ej6_logic_functions

// File: doc/ej6_logic_functions.md
Name: ej6_logic_functions

Overview:
- Evaluates three fixed 4-input Boolean functions f, g, h of {A,B,C,D}, with A as the MSB.
- Each function is produced in three independent realizations:
  - a canonical truth-table form (f, g, h);
  - a minimal sum-of-products form (fs, gs, hs);
  - a minimal product-of-sums form (fp, gp, hp).
- All nine results are registered.
- The block serves as a logic-minimization exercise unit and self-consistency checker in the TP2 lab set.

Parameters:
- None. Input width is fixed at 4 (K=4, N=15 internal constants).

Ports:
- clk    input   1  system clock, rising-edge active
- reset  input   1  asynchronous, active-high reset
- A      input   1  function input, MSB of index n={A,B,C,D}
- B      input   1  function input
- C      input   1  function input
- D      input   1  function input, LSB
- f      output  1  registered f, canonical (truth-table) form
- g      output  1  registered g, canonical form
- h      output  1  registered h, canonical form
- fs     output  1  registered f, minimal SOP form
- fp     output  1  registered f, minimal POS form
- gs     output  1  registered g, minimal SOP form
- gp     output  1  registered g, minimal POS form
- hs     output  1  registered h, minimal SOP form
- hp     output  1  registered h, minimal POS form

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Index: n = {A,B,C,D}, 0..15.
- Function definitions:
  - f = Σm(0,1,2,3,7,8,10,13,15). Truth table 16'hA58F (bit n = value at n).
  - g = Σm(4,5,6,7,12,13). Truth table 16'h30F0.
  - h = Σm(1,5,9,11,13,15). Truth table 16'hAA22.
- Canonical outputs f, g, h: bit-select of the truth-table constant, indexed by n.
- SOP outputs must be implemented as an OR of AND terms:
  - fs = A'B' + B'D' + BCD + ABD
  - gs = A'B + BC'
  - hs = C'D + AD
- POS outputs must be implemented as an AND of OR terms, derived from the maxterms:
  - f maxterms: 4,5,6,9,11,12,14
  - g maxterms: 0,1,2,3,8,9,10,11,14,15
  - h maxterms: 0,2,3,4,6,7,8,10,12,14
- POS outputs must be minimal, for example:
  - hp = D(A+C')
  - gp = B(A'+C')
- Timing:
  - All nine outputs are captured on the rising clk edge.
  - Latency is 1 cycle from input change to output.
  - No handshake; inputs are sampled every cycle.
- Reset:
  - While reset=1, all nine outputs are 0 immediately, without waiting for a clock.
  - The first capture occurs on the first rising edge after reset deasserts.
  - Asserting reset mid-sweep clears the outputs at once. Evaluation resumes on the next edge after release, with no residual state.
- Invariant: every cycle outside reset, f==fs==fp, g==gs==gp and h==hs==hp.
- Boundaries:
  - n=0 and n=15 are valid, with no wrap concerns.
  - Inputs changing every cycle must be tracked without gaps.

Decomposition:
- Shared package ej6_pkg:
  - constants F_TT=16'hA58F, G_TT=16'h30F0, H_TT=16'hAA22;
  - K=4, N=15;
  - reset value 1'b0.
- One sub-module, ej6_func_core: purely combinational, inputs A..D, nine unregistered outputs, holding the three realizations per function.
- Top level: instantiates ej6_func_core once and adds the 9-bit output register with asynchronous reset.

Test Plan:
- Reset: reset=1 with n=13 applied, no clock → all nine outputs 0. Release reset, one clk edge → f=g=h=1 and all s/p copies equal 1.
- Exhaustive sweep: n=0..15, one clock each. One cycle later each output equals its truth-table bit (0xA58F / 0x30F0 / 0xAA22 at bit n).
- Spot vectors:
  - n=0 → f=1, g=0, h=0
  - n=6 → f=0, g=1, h=0
  - n=9 → f=0, g=0, h=1
  - n=15 → f=1, g=0, h=1
- Consistency: across the full sweep, assert fs==fp==f, gs==gp==g and hs==hp==h on every cycle after reset release.
- Mid-sweep reset: assert reset asynchronously during n=7 → outputs drop to 0 before the next edge. After release, n=7 yields f=1, g=1, h=0 after one edge.
